// File: rtl/oclib_csr_arbiter_if.sv
// ---------------------------------------------------------------------------
// oclib_csr_arbiter_if
// Bundles the upstream (requester) and downstream (CSR target) signals of
// oclib_csr_arbiter.
//   slave  : arbiter view (takes requests, drives the target port)
//   master : environment view (requesters plus downstream target)
// Signals:
//   inReq/inCsr         per-requester request and flattened request words
//   inAck/inRdata/inError  one-hot completion pulse and response
//   outValid/outCsr     downstream request
//   outReady/outRdata/outError  downstream completion and response
//   grantId             index of current/last grant
// ---------------------------------------------------------------------------
interface oclib_csr_arbiter_if #(
  parameter int Requesters = 2,
  parameter int CsrWidth   = 64,
  parameter int DataWidth  = 32
);
  localparam int GrantWidth = $clog2(Requesters);

  logic [Requesters-1:0]          inReq;
  logic [Requesters*CsrWidth-1:0] inCsr;
  logic [Requesters-1:0]          inAck;
  logic [DataWidth-1:0]           inRdata;
  logic                           inError;
  logic                           outValid;
  logic [CsrWidth-1:0]            outCsr;
  logic                           outReady;
  logic [DataWidth-1:0]           outRdata;
  logic                           outError;
  logic [GrantWidth-1:0]          grantId;

  modport slave (
    input  inReq, inCsr, outReady, outRdata, outError,
    output inAck, inRdata, inError, outValid, outCsr, grantId
  );

  modport master (
    output inReq, inCsr, outReady, outRdata, outError,
    input  inAck, inRdata, inError, outValid, outCsr, grantId
  );
endinterface

// File: rtl/oclib_csr_arbiter.sv
// ---------------------------------------------------------------------------
// oclib_csr_arbiter
// Round-robin arbiter sharing one downstream CSR target between several
// upstream CSR masters. A granted request is registered onto outCsr and held
// until the target answers with outReady; the response goes back only to the
// granted requester as a one-cycle inAck pulse, followed by one dead cycle
// (DONE) so the requester can release inReq before re-arbitration.
//
// Ports:
//   clock   sole clock
//   resetn  synchronous active-low reset
//   csr     oclib_csr_arbiter_if.slave (requests, responses, downstream port)
//
// Optional feature (macro OC_CSR_ARBITER_TIMEOUT_EN):
//   a 16-bit BUSY counter; if the target has not answered by the time it
//   reaches TimeoutCycles-1, the requester is acked with inError=1 and
//   inRdata=0. outReady in that same cycle still wins.
// ---------------------------------------------------------------------------
module oclib_csr_arbiter #(
  parameter int Requesters    = 2,
  parameter int CsrWidth      = 64,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input logic                clock,
  input logic                resetn,
  oclib_csr_arbiter_if.slave csr
);
  localparam int GW = $clog2(Requesters);

  if (Requesters < 2 || Requesters > 16 || TimeoutCycles < 2) begin : g_param_err
    $error("oclib_csr_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [CsrWidth-1:0]   csr_q, csr_d;
  logic [Requesters-1:0] ack_q, ack_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [GW-1:0]         gid_q, gid_d;
  logic [GW-1:0]         last_q, last_d;
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  // Unflatten the request words so the grant index can select one directly.
  logic [CsrWidth-1:0] req_csr [Requesters];
  for (genvar i = 0; i < Requesters; i++) begin : g_unpack
    assign req_csr[i] = csr.inCsr[i*CsrWidth +: CsrWidth];
  end

  // Round-robin pick: scan upward from lastGrant+1, wrapping. Offset
  // Requesters lands back on lastGrant itself, so it is considered last.
  logic [GW-1:0] pick, cand;
  logic          found;
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= Requesters; k++) begin
      cand = GW'((int'(last_q) + k) % Requesters);
      if (!found && csr.inReq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    csr_d   = csr_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    gid_d   = gid_q;
    last_d  = last_q;
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          csr_d   = req_csr[pick];
          valid_d = 1'b1;
          gid_d   = pick;
          last_d  = pick;
          state_d = BUSY;
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (csr.outReady) begin
          ack_d[gid_q] = 1'b1;
          rdata_d      = csr.outRdata;
          err_d        = csr.outError;
          valid_d      = 1'b0;
          state_d      = DONE;
        end
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
        else if (cnt_q == 16'(TimeoutCycles - 1)) begin
          ack_d[gid_q] = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b1;
          valid_d      = 1'b0;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      csr_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gid_q   <= '0;
      // Pointer at the top index so the next scan starts at requester 0.
      last_q  <= GW'(Requesters - 1);
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      csr_q   <= csr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
`ifdef OC_CSR_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign csr.outValid = valid_q;
  assign csr.outCsr   = csr_q;
  assign csr.inAck    = ack_q;
  assign csr.inRdata  = rdata_q;
  assign csr.inError  = err_q;
  assign csr.grantId  = gid_q;
endmodule

// File: tb/tb_oclib_csr_arbiter.sv
module tb_oclib_csr_arbiter;
  localparam int R  = 2;
  localparam int CW = 64;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  oclib_csr_arbiter_if #(.Requesters(R), .CsrWidth(CW), .DataWidth(DW)) bus ();

  oclib_csr_arbiter #(
    .Requesters(R), .CsrWidth(CW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .csr   (bus)
  );

  typedef struct { int idx; logic [CW-1:0] csr; } req_t;
  typedef struct { int idx; logic [DW-1:0] rdata; logic err; } ack_t;
  typedef struct { logic [8*16-1:0] name; logic [63:0] got; logic [63:0] exp; } dchk_t;

  req_t  exp_req[$];
  ack_t  exp_ack[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: compares every downstream grant and every ack against the
  // scoreboard queues, plus any point checks queued by the stimulus.
  initial begin : monitor
    dchk_t d;
    req_t  r;
    ack_t  a;
    logic  prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        checks++;
        if (d.got !== d.exp) begin
          errors++;
          $display("FAIL %0s: got %0h, expected %0h", d.name, d.got, d.exp);
        end
      end
      if (resetn) begin
        if (bus.outValid && !prev_valid) begin
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: outCsr %0h grantId %0d", bus.outCsr, bus.grantId);
          end else begin
            r = exp_req.pop_front();
            if (bus.outCsr !== r.csr || int'(bus.grantId) != r.idx) begin
              errors++;
              $display("FAIL grant: outCsr %0h grantId %0d, expected %0h grantId %0d",
                       bus.outCsr, bus.grantId, r.csr, r.idx);
            end
          end
        end
        if (bus.inAck !== '0) begin
          checks++;
          if (exp_ack.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: inAck %b", bus.inAck);
          end else begin
            a = exp_ack.pop_front();
            if (bus.inAck !== R'(1 << a.idx) || bus.inRdata !== a.rdata || bus.inError !== a.err) begin
              errors++;
              $display("FAIL ack: inAck %b rdata %0h err %b, expected idx %0d rdata %0h err %b",
                       bus.inAck, bus.inRdata, bus.inError, a.idx, a.rdata, a.err);
            end
          end
        end
      end
      prev_valid = bus.outValid;
    end
  end

  task automatic dchk(input logic [8*16-1:0] name, input logic [63:0] got, input logic [63:0] exp);
    dchk_t d;
    d.name = name; d.got = got; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_req(input int idx, input logic [CW-1:0] c);
    req_t r;
    r.idx = idx; r.csr = c;
    exp_req.push_back(r);
  endtask

  task automatic push_ack(input int idx, input logic [DW-1:0] rd, input logic er);
    ack_t a;
    a.idx = idx; a.rdata = rd; a.err = er;
    exp_ack.push_back(a);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.outValid && cyc < 50) begin tick(); cyc++; end
    if (!bus.outValid) dchk("wait_valid", 64'd0, 64'd1);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (bus.inAck === '0 && cyc < 50) begin tick(); cyc++; end
    if (bus.inAck === '0) dchk("wait_ack", 64'd0, 64'd1);
  endtask

  task automatic respond(input int delay, input logic [DW-1:0] rd, input logic er);
    repeat (delay) tick();
    bus.outReady = 1'b1; bus.outRdata = rd; bus.outError = er;
    tick();
    bus.outReady = 1'b0; bus.outError = 1'b0;
  endtask

  initial begin : stim
    int c;
    bus.inReq = '0; bus.inCsr = '0;
    bus.outReady = 1'b0; bus.outRdata = '0; bus.outError = 1'b0;
    tick(3);
    dchk("rst_valid",  64'(bus.outValid), 64'd0);
    dchk("rst_csr",    bus.outCsr,        64'd0);
    dchk("rst_ack",    64'(bus.inAck),    64'd0);
    dchk("rst_rdata",  64'(bus.inRdata),  64'd0);
    dchk("rst_err",    64'(bus.inError),  64'd0);
    dchk("rst_gid",    64'(bus.grantId),  64'd0);
    resetn = 1'b1;
    tick();

    // Single request with a 3-cycle target delay.
    bus.inCsr[0 +: CW] = 64'h0000_0005_0000_0010;
    push_req(0, 64'h0000_0005_0000_0010);
    push_ack(0, 32'hCAFE_F00D, 1'b0);
    bus.inReq = 2'b01;
    wait_valid(c);
    respond(3, 32'hCAFE_F00D, 1'b0);
    bus.inReq = 2'b00;
    tick(2);
    dchk("rdata_hold", 64'(bus.inRdata), 64'hCAFE_F00D);
    dchk("ack_idle",   64'(bus.inAck),   64'd0);

    // Both requesters from reset with outReady tied high: 0,1,0,1.
    resetn = 1'b0;
    bus.inCsr[0 +: CW]  = 64'h0000_0001_AAAA_0000;
    bus.inCsr[CW +: CW] = 64'h0000_0002_BBBB_0000;
    bus.inReq = 2'b11;
    bus.outReady = 1'b1; bus.outRdata = 32'h1234_5678;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      push_req(i % 2, (i % 2 == 0) ? 64'h0000_0001_AAAA_0000 : 64'h0000_0002_BBBB_0000);
      push_ack(i % 2, 32'h1234_5678, 1'b0);
    end
    resetn = 1'b1;
    wait_ack(c);
    dchk("first_ack_lat", 64'(c), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      wait_ack(c);
      dchk("ack_spacing", 64'(c + 1), 64'd3);
    end
    bus.inReq = 2'b00;
    bus.outReady = 1'b0;
    tick(3);

    // Error passthrough (pointer now at 1, so requester 0 is next).
    bus.inCsr[0 +: CW] = 64'h0000_0003_0000_0C00;
    push_req(0, 64'h0000_0003_0000_0C00);
    push_ack(0, 32'h0000_BEEF, 1'b1);
    bus.inReq = 2'b01;
    wait_valid(c);
    respond(0, 32'h0000_BEEF, 1'b1);
    bus.inReq = 2'b00;
    tick(2);

    // Reset two cycles into BUSY: transaction abandoned, pointer reset.
    bus.inCsr[0 +: CW] = 64'h0000_0004_0000_0D00;
    push_req(0, 64'h0000_0004_0000_0D00);
    bus.inReq = 2'b01;
    wait_valid(c);
    tick(2);
    resetn = 1'b0;
    tick();
    dchk("midrst_valid", 64'(bus.outValid), 64'd0);
    dchk("midrst_ack",   64'(bus.inAck),    64'd0);
    bus.inReq = 2'b10;
    bus.inCsr[CW +: CW] = 64'h0000_0006_0000_0E00;
    tick();
    resetn = 1'b1;
    push_req(1, 64'h0000_0006_0000_0E00);
    push_ack(1, 32'h0BAD_CAFE, 1'b0);
    wait_valid(c);
    respond(1, 32'h0BAD_CAFE, 1'b0);
    bus.inReq = 2'b00;
    tick(2);

    // Requester drops inReq one cycle into BUSY.
    bus.inCsr[0 +: CW] = 64'h0000_0007_0000_0F00;
    push_req(0, 64'h0000_0007_0000_0F00);
    push_ack(0, 32'h0000_0077, 1'b0);
    bus.inReq = 2'b01;
    wait_valid(c);
    tick();
    bus.inReq = 2'b00;
    respond(2, 32'h0000_0077, 1'b0);
    tick(6);
    dchk("no_regrant", 64'(bus.outValid), 64'd0);

`ifdef OC_CSR_ARBITER_TIMEOUT_EN
    // Target never answers: error ack after TO BUSY cycles, zero data.
    bus.inCsr[CW +: CW] = 64'h0000_0008_0000_1000;
    bus.outRdata = 32'hDEAD_BEEF;
    push_req(1, 64'h0000_0008_0000_1000);
    push_ack(1, 32'h0, 1'b1);
    bus.inReq = 2'b10;
    wait_valid(c);
    wait_ack(c);
    dchk("timeout_cycles", 64'(c), 64'(TO));
    bus.inReq = 2'b00;
    tick(2);
    bus.inCsr[0 +: CW] = 64'h0000_0009_0000_1100;
    push_req(0, 64'h0000_0009_0000_1100);
    push_ack(0, 32'h0000_0042, 1'b0);
    bus.inReq = 2'b01;
    wait_valid(c);
    respond(1, 32'h0000_0042, 1'b0);
    bus.inReq = 2'b00;
    tick(2);
`endif

    c = 0;
    while ((exp_req.size() + exp_ack.size()) != 0 && c < 20) begin tick(); c++; end
    dchk("queues_empty", 64'(exp_req.size() + exp_ack.size()), 64'd0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
